sync_fifo_stream_rd: RTL and testbench
======================================

// Module: sync_fifo_stream_rd
// PURPOSE
//   Read-side adapter for the sync FIFO. Pops words from the FIFO read port
//   (rd_en/data_out/empty, 1-cycle registered read latency) and presents them
//   on a valid/ready stream master. A 2-entry local buffer absorbs the read
//   latency, so back-to-back transfers run at 1 word/cycle with registered outputs.
// PARAMETERS
//   DATA_WIDTH  8   width of the FIFO word and of m_data
//   CNT_WIDTH   16  width of the xfer_cnt transfer counter (wraps)
// PORTS
//   clk         in   1           system clock, rising edge
//   rst         in   1           asynchronous reset, active-high
//   fifo_empty  in   1           FIFO empty flag
//   fifo_data   in   DATA_WIDTH  FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  1           FIFO read request (combinational)
//   m_valid     out  1           stream data valid (registered)
//   m_ready     in   1           stream sink ready
//   m_data      out  DATA_WIDTH  stream data (registered, head of local buffer)
//   xfer_cnt    out  CNT_WIDTH   count of completed m_valid&&m_ready handshakes
// BEHAVIOUR
//   Reset (async assert, sync release): buffer count 0, inflight 0, m_valid 0,
//     m_data 0, xfer_cnt 0; fifo_rd_en is 0 while rst is high.
//   State: buf[0:1] words, buf_cnt 0..2, wr/rd pointers 1 bit, inflight 1 bit.
//   pop = m_valid && m_ready. issue = !fifo_empty && (buf_cnt + inflight - pop) < 2.
//   fifo_rd_en = issue. Never asserted when fifo_empty=1 (no underflow reads).
//   inflight <= issue every cycle. When inflight=1, fifo_data is written into
//     buf[wr_ptr] at that clock edge; wr_ptr toggles.
//   buf_cnt next = buf_cnt + inflight - pop; the issue rule keeps it <= 2,
//     so a captured word never overflows the buffer.
//   m_valid = (buf_cnt != 0); m_data = buf[rd_ptr]; rd_ptr toggles on pop.
//   Both pointers wrap 1->0.
//   Latency: rd_en at cycle N -> word in buffer at N+1 edge -> m_valid at N+2
//     (first word 2 cycles after fifo_empty deasserts, with buffer empty).
//   Throughput: m_ready held high and FIFO non-empty -> 1 word/cycle
//     (steady state buf_cnt=1, inflight=1).
//   Backpressure: m_valid stays high and m_data stays stable until pop. Reads
//     stop once buf_cnt + inflight reaches 2.
//   Simultaneous capture and pop: both take effect. buf_cnt is unchanged and the
//     order is preserved.
//   Ordering: words leave in exactly FIFO pop order; no drop, no duplicate.
//   xfer_cnt increments by 1 per pop and wraps 2^CNT_WIDTH-1 -> 0.
//   Reset mid-transfer: buffered and inflight words are discarded. The FIFO
//     side must be reset together with this block.
// TESTING
//   (bench: sync FIFO DATA_WIDTH=8 DEPTH=8 as source, 20 ns clock)
//   1 Reset: rst=1 with FIFO holding data -> fifo_rd_en=0, m_valid=0,
//     m_data=0, xfer_cnt=0 throughout.
//   2 Stream: write 8 words 0x11..0x88, m_ready=1 -> m_valid first high 2 cycles
//     after the first read; 8 consecutive beats 0x11..0x88; xfer_cnt=8;
//     no rd_en while empty.
//   3 Backpressure: 4 words queued, m_ready=0 for 10 cycles -> exactly 2
//     fifo_rd_en pulses; m_data=first word, stable. Then release -> all 4
//     delivered in order.
//   4 Random m_ready (50%), with concurrent FIFO writes of $random for 200
//     cycles -> scoreboard matches FIFO write order; FIFO never underflows;
//     buf_cnt <= 2.
//   5 Async reset mid-burst: assert rst between clock edges with 2 words
//     buffered -> m_valid drops immediately; after release xfer_cnt=0.
//     Streaming resumes cleanly after the FIFO is refilled.
//   6 Wrap: CNT_WIDTH=4, 17 transfers -> xfer_cnt reads 15 then 0 then 1.

Source files
------------

// File: rtl/sync_fifo_stream_rd.sv
// sync_fifo_stream_rd
//   Read-side adapter for the sync FIFO. It pops words from the FIFO read port
//   and presents them on a valid/ready stream master. The FIFO has a 1-cycle
//   registered read latency. A 2-entry local buffer absorbs that latency, so
//   back-to-back transfers run at one word per cycle with registered outputs.
//
// Parameters
//   DATA_WIDTH  width of the FIFO word and of m_data
//   CNT_WIDTH   width of the wrapping xfer_cnt transfer counter
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO read request (combinational, held low during reset)
//   m_valid     stream data valid (registered)
//   m_ready     stream sink ready
//   m_data      stream data, head of the local buffer (registered)
//   xfer_cnt    count of completed m_valid && m_ready handshakes (wraps)
module sync_fifo_stream_rd #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic [1:0]            buf_cnt;
    logic [1:0]            buf_cnt_next;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  rd_ptr_next;
    logic                  inflight;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] head_next;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ_after_pop;

    always_comb begin
        pop           = valid_q && m_ready;
        // Words held or already requested once this cycle's pop is taken.
        // A new read is allowed only if its word will still find a free slot.
        occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        issue         = !rst && !fifo_empty && (occ_after_pop < 3'd2);
        buf_cnt_next  = buf_cnt + {1'b0, inflight} - {1'b0, pop};
        rd_ptr_next   = rd_ptr ^ pop;
        // m_data is kept in its own register, equal to buf_mem[rd_ptr]. When
        // the next head slot is the one being written this edge, forward the
        // incoming FIFO word.
        if (inflight && (wr_ptr == rd_ptr_next)) begin
            head_next = fifo_data;
        end else begin
            head_next = buf_mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            buf_cnt    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            inflight   <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            xfer_cnt   <= '0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                buf_mem[wr_ptr] <= fifo_data;
                wr_ptr          <= ~wr_ptr;
            end
            rd_ptr  <= rd_ptr_next;
            buf_cnt <= buf_cnt_next;
            valid_q <= (buf_cnt_next != 2'd0);
            data_q  <= head_next;
            if (pop) begin
                xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign fifo_rd_en = issue;
    assign m_valid    = valid_q;
    assign m_data     = data_q;

endmodule

// File: tb/tb_sync_fifo_stream_rd.sv
// Testbench for sync_fifo_stream_rd. The source is a queue-based model of an
// 8-deep sync FIFO with a registered read. Every word that the FIFO accepts is
// pushed into the expected queue. The negedge monitor pops that queue on every
// handshake and compares the popped word against the DUT output.
`timescale 1ns/1ps
module tb_sync_fifo_stream_rd;
    localparam int unsigned DW         = 8;
    localparam int unsigned CW         = 4;
    localparam int          FIFO_DEPTH = 8;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          fifo_rst   = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready    = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] xfer_cnt;
    logic          wr_en      = 1'b0;
    logic [DW-1:0] wr_data    = '0;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt   = '0;
    int            rd_total  = 0;
    int            pop_total = 0;
    logic          prev_rd   = 1'b0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic [DW-1:0] sb_word;
    int            occ;
    int            buffered;
    int            rd_base;
    int            first_rd, first_v, last_v, nvalid;
    logic [CW-1:0] seen[$];
    logic [CW-1:0] prev_cnt;

    always #10 clk = ~clk;

    sync_fifo_stream_rd #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input logic cond);
        tests++;
        if (cond !== 1'b1) begin
            fails++;
            $display("FAIL %s: condition is %b, expected 1", name, cond);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        exp_cnt   = '0;
        rd_total  = 0;
        pop_total = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        wr_en    = 1'b0;
        rst      = 1'b1;
        fifo_rst = 1'b1;
        clear_sb();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        fifo_rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n       = 0;
        m_ready = 1'b1;
        wr_en   = 1'b0;
        while (n < 100 && !(exp_q.size() == 0 && !m_valid && fifo_empty && !fifo_rd_en)) begin
            tick();
            n++;
        end
        check_true({name, "_drained"}, exp_q.size() == 0 && !m_valid);
    endtask

    // Source FIFO: 8 deep, 1-cycle registered read, empty updated at the edge.
    always @(posedge clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            fq.delete();
            fifo_data  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en) begin
                check_true("fifo_no_underflow", fq.size() != 0);
                if (fq.size() != 0) fifo_data <= fq.pop_front();
                rd_total++;
            end
            if (wr_en && fq.size() < FIFO_DEPTH) begin
                fq.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Stream monitor: scoreboard, counter, backpressure and occupancy checks.
    always @(negedge clk) begin
        if (!rst) begin
            // Words already captured = reads issued so far minus the one in
            // flight minus the words delivered.
            buffered = rd_total - int'(prev_rd) - pop_total;
            check("m_valid_vs_buffered", 32'(m_valid), 32'(buffered != 0));
            if (hold_prev) begin
                check_true("bp_valid_held", m_valid);
                check("bp_data_stable", 32'(m_data), 32'(hold_data));
            end
            occ = rd_total + int'(fifo_rd_en) - pop_total - int'(m_valid && m_ready);
            check_true("occupancy_le_2", occ <= 2);
            if (m_valid && m_ready) begin
                check_true("sb_word_expected", exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    sb_word = exp_q.pop_front();
                    check("sb_data", 32'(m_data), 32'(sb_word));
                end
                check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
                exp_cnt = exp_cnt + CW'(1);
                pop_total++;
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            prev_rd   = fifo_rd_en;
        end else begin
            hold_prev = 1'b0;
            prev_rd   = 1'b0;
        end
    end

    initial begin
        // Reset held while the FIFO is filled: the adapter must stay quiet.
        repeat (2) tick();
        fifo_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en   = (i < 3);
            wr_data = 8'(8'hC0 + i);
            @(negedge clk);
            check("rst_rd_en", 32'(fifo_rd_en), 32'(0));
            check("rst_m_valid", 32'(m_valid), 32'(0));
            check("rst_m_data", 32'(m_data), 32'(0));
            check("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
            tick();
        end
        wr_en = 1'b0;
        rst   = 1'b0;
        drain("t1");

        // Stream 0x11..0x88 with the sink always ready.
        do_reset();
        m_ready  = 1'b1;
        first_rd = -1;
        first_v  = -1;
        last_v   = -1;
        nvalid   = 0;
        fork
            begin
                for (int k = 1; k <= 8; k++) begin
                    wr_en   = 1'b1;
                    wr_data = 8'(k * 17);
                    tick();
                end
                wr_en = 1'b0;
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    @(negedge clk);
                    if (fifo_rd_en && first_rd < 0) first_rd = c;
                    if (m_valid) begin
                        if (first_v < 0) first_v = c;
                        last_v = c;
                        nvalid++;
                    end
                end
            end
        join
        check("stream_latency", 32'(first_v - first_rd), 32'(2));
        check("stream_beats", 32'(nvalid), 32'(8));
        check("stream_consecutive", 32'(last_v - first_v), 32'(7));
        check("stream_xfer_cnt", 32'(xfer_cnt), 32'(8));
        check("stream_sb_empty", 32'(exp_q.size()), 32'(0));

        // Backpressure: only two reads may be issued while the sink stalls.
        m_ready = 1'b0;
        rd_base = rd_total;
        for (int k = 0; k < 4; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'hA1 + k);
            tick();
        end
        wr_en = 1'b0;
        repeat (10) tick();
        check("bp_rd_pulses", 32'(rd_total - rd_base), 32'(2));
        check_true("bp_valid", m_valid);
        check("bp_head", 32'(m_data), 32'(8'hA1));
        drain("bp");

        // Random sink readiness with concurrent random FIFO writes.
        for (int c = 0; c < 200; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1 && fq.size() < FIFO_DEPTH) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        drain("random");

        // Asynchronous reset with two words buffered.
        do_reset();
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            tick();
        end
        wr_en   = 1'b0;
        m_ready = 1'b1;
        repeat (2) tick();
        m_ready = 1'b0;
        repeat (4) tick();
        check("pre_rst_xfer_cnt", 32'(xfer_cnt), 32'(2));
        check_true("pre_rst_valid", m_valid);
        @(negedge clk);
        #3;
        rst      = 1'b1;
        fifo_rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(m_valid), 32'(0));
        check("async_rst_m_data", 32'(m_data), 32'(0));
        check("async_rst_rd_en", 32'(fifo_rd_en), 32'(0));
        check("async_rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        clear_sb();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        fifo_rst = 1'b0;
        check("post_rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h5A + k);
            tick();
        end
        drain("post_rst");

        // Counter wrap: 17 transfers on a 4-bit counter.
        do_reset();
        m_ready = 1'b1;
        seen.delete();
        prev_cnt = xfer_cnt;
        fork
            begin
                int n;
                n = 0;
                while (n < 17) begin
                    if (fq.size() < FIFO_DEPTH) begin
                        wr_en   = 1'b1;
                        wr_data = 8'($urandom);
                        n++;
                    end else begin
                        wr_en = 1'b0;
                    end
                    tick();
                end
                wr_en = 1'b0;
            end
            begin
                for (int c = 0; c < 300 && seen.size() < 17; c++) begin
                    @(negedge clk);
                    if (xfer_cnt != prev_cnt) begin
                        seen.push_back(xfer_cnt);
                        prev_cnt = xfer_cnt;
                    end
                end
            end
        join
        check("wrap_count_changes", 32'(seen.size()), 32'(17));
        if (seen.size() == 17) begin
            check("wrap_15", 32'(seen[14]), 32'(15));
            check("wrap_0", 32'(seen[15]), 32'(0));
            check("wrap_1", 32'(seen[16]), 32'(1));
        end
        drain("wrap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
